// File: rtl/fl_gen_pkg.sv
// Shared types and LFSR helpers for the FrameLink pseudo-random frame generator.
// Optional macro FL_GEN_SEQNUM_EN is consumed by fl_lfsr_frame_gen, not here.
package fl_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_SEND,
        S_FIN
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    function automatic logic [31:0] next_lfsr32(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/fl_gen_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; an all-zero seed is replaced so the
// register can never lock up.
module fl_gen_lfsr32
    import fl_gen_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [31:0] SEED_IN,
    input  logic        EN,
    output logic [31:0] STATE
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            STATE <= '0;
        end else if (LOAD) begin
            STATE <= (SEED_IN == '0) ? ZERO_SEED_SUB : SEED_IN;
        end else if (EN) begin
            STATE <= next_lfsr32(STATE);
        end
    end

endmodule

// File: rtl/fl_lfsr_frame_gen.sv
// FrameLink stimulus source: FRAME_COUNT single-part frames of LFSR length and payload.
// Define FL_GEN_SEQNUM_EN to place the frame index in TX_DATA[31:0] of each SOF word.
module fl_lfsr_frame_gen
    import fl_gen_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH     = 64,
    parameter  int unsigned CNT_WIDTH      = 16,
    parameter  int unsigned MIN_LEN        = 64,
    parameter  int unsigned LEN_RANGE_LOG2 = 6,
    localparam int unsigned REM_W          = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           SEED,
    input  logic [CNT_WIDTH-1:0]  FRAME_COUNT,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [REM_W-1:0]      TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOF_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N
);

    localparam int unsigned K        = DATA_WIDTH / 32;
    localparam int unsigned BPW      = DATA_WIDTH / 8;
    localparam int unsigned BPW_LOG2 = $clog2(BPW);
    localparam logic [31:0] LEN_MASK = 32'((64'd1 << LEN_RANGE_LOG2) - 64'd1);

    if ((DATA_WIDTH % 32) != 0 || DATA_WIDTH < 32 || DATA_WIDTH > 256) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 32 in 32..256");
    end
    if (MIN_LEN < 1 || (MIN_LEN + (2 ** LEN_RANGE_LOG2) - 1) > 65535) begin : g_bad_len
        $error("frame length window must lie within 1..65535 bytes");
    end

    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  frames_total, frame_idx, idx_inc;
    logic [15:0]           words, word_idx, len_bytes, words_calc;
    logic [REM_W-1:0]      rem_r, rem_calc;
    logic [31:0]           seed_eff, len_state, len_step;
    logic [DATA_WIDTH-1:0] lane_data;
    logic                  start_acc, xfer, last_word, frame_last;

    assign seed_eff   = (SEED == '0) ? ZERO_SEED_SUB : SEED;
    assign start_acc  = (state == S_IDLE) && START;
    assign xfer       = (state == S_SEND) && !TX_DST_RDY_N;
    assign last_word  = (word_idx == words - 16'd1);
    assign idx_inc    = frame_idx + CNT_WIDTH'(1);
    assign frame_last = (idx_inc == frames_total);

    // Length is taken from the value the length LFSR steps to during S_LEN
    assign len_step   = next_lfsr32(len_state);
    assign len_bytes  = 16'(MIN_LEN) + 16'(len_step & LEN_MASK);
    assign words_calc = 16'((17'(len_bytes) + 17'(BPW - 1)) >> BPW_LOG2);
    assign rem_calc   = REM_W'(len_bytes - 16'd1);

    for (genvar i = 0; i < K; i++) begin : g_lane
        fl_gen_lfsr32 u_lane (
            .CLK     (CLK),
            .RESET   (RESET),
            .LOAD    (start_acc),
            .SEED_IN (seed_eff + 32'(i)),
            .EN      (xfer),
            .STATE   (lane_data[32*i +: 32])
        );
    end

    fl_gen_lfsr32 u_len (
        .CLK     (CLK),
        .RESET   (RESET),
        .LOAD    (start_acc),
        .SEED_IN (~seed_eff),
        .EN      (state == S_LEN),
        .STATE   (len_state)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (START) state_next = S_LEN;
            S_LEN:   state_next = (frames_total == '0) ? S_FIN : S_SEND;
            S_SEND:  if (xfer && last_word) state_next = frame_last ? S_FIN : S_LEN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Run bookkeeping: frame count, per-frame word geometry, position within frame
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frames_total <= '0;
            frame_idx    <= '0;
            words        <= '0;
            word_idx     <= '0;
            rem_r        <= '0;
        end else begin
            if (start_acc) begin
                frames_total <= FRAME_COUNT;
                frame_idx    <= '0;
            end
            if (state == S_LEN) begin
                words    <= words_calc;
                rem_r    <= rem_calc;
                word_idx <= '0;
            end
            if (xfer) begin
                if (last_word) begin
                    word_idx  <= '0;
                    frame_idx <= idx_inc;
                end else begin
                    word_idx <= word_idx + 16'd1;
                end
            end
        end
    end

    // Outputs decode registered state only, so they hold while the sink stalls
    always_comb begin
        BUSY         = 1'b0;
        DONE         = 1'b0;
        TX_DATA      = '0;
        TX_REM       = '0;
        TX_SOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        case (state)
            S_LEN: BUSY = 1'b1;
            S_SEND: begin
                BUSY         = 1'b1;
                TX_SRC_RDY_N = 1'b0;
                TX_DATA      = lane_data;
`ifdef FL_GEN_SEQNUM_EN
                if (word_idx == '0) TX_DATA[31:0] = 32'(frame_idx);
`endif
                TX_SOF_N     = (word_idx != '0);
                TX_SOP_N     = (word_idx != '0);
                TX_EOF_N     = !last_word;
                TX_EOP_N     = !last_word;
                TX_REM       = last_word ? rem_r : '0;
            end
            S_FIN: DONE = 1'b1;
            default: ;
        endcase
    end

endmodule
